// File: rtl/booth_secuencial.sv
// Radix-2 Booth sequential signed multiplier: captures operands on a rising edge of
// inicio, runs N add/sub+shift iterations, then holds the 2N-bit product.
module booth_secuencial #(
  parameter int N = 8
) (
  input  logic           CLK100MHZ,
  input  logic           reset,
  input  logic [N-1:0]   multiplicador,
  input  logic [N-1:0]   multiplicando,
  input  logic           inicio,
  output logic [2*N-1:0] producto,
  output logic           listo,
  output logic           ocupado
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        r_state, w_state_next;
  logic [N:0]    r_a, r_m, w_a_sum, w_a_new;
  logic [N-1:0]  r_q, w_q_new;
  logic          r_q_1, w_q_1_new;
  logic          r_inicio_q;
  logic [CW-1:0] r_cnt;
  logic          w_start, w_last;

  assign w_start = inicio & ~r_inicio_q;
  assign w_last  = (r_cnt == LAST);

  // One Booth step: add/sub on N+1 bits, then arithmetic shift of {A', Q, Q_1}.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_a_sum = r_a;
    case ({r_q[0], r_q_1})
      2'b01:   w_a_sum = r_a + r_m;
      2'b10:   w_a_sum = r_a - r_m;
      default: w_a_sum = r_a;
    endcase
    {w_a_new, w_q_new, w_q_1_new} = {w_a_sum[N], w_a_sum, r_q};
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = CALC;
      CALC:    if (w_last) w_state_next = DONE;
      DONE:    if (!inicio) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // inicio_q resets to 1 so a level held through reset never counts as a start edge.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_inicio_q <= 1'b1;
      r_a        <= '0;
      r_q        <= '0;
      r_q_1      <= 1'b0;
      r_m        <= '0;
      r_cnt      <= '0;
      producto   <= '0;
      listo      <= 1'b0;
      ocupado    <= 1'b0;
    end else begin
      r_inicio_q <= inicio;
      ocupado    <= (w_state_next == CALC);
      listo      <= (w_state_next == DONE);
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_m   <= {multiplicando[N-1], multiplicando};
            r_q   <= multiplicador;
            r_a   <= '0;
            r_q_1 <= 1'b0;
            r_cnt <= '0;
          end
        end
        CALC: begin
          r_a   <= w_a_new;
          r_q   <= w_q_new;
          r_q_1 <= w_q_1_new;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) producto <= {w_a_new[N-1:0], w_q_new};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_secuencial.sv
// Self-checking bench for booth_secuencial: scoreboard of expected products,
// latency/busy checks, hold/re-arm, reset abort and operand-change scenarios.
module tb_booth_secuencial;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  multiplicador, multiplicando;
  logic        inicio;
  logic [15:0] producto;
  logic        listo, ocupado;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] sb[$];

  booth_secuencial #(.N(8)) dut (
    .CLK100MHZ     (clk),
    .reset         (reset),
    .multiplicador (multiplicador),
    .multiplicando (multiplicando),
    .inicio        (inicio),
    .producto      (producto),
    .listo         (listo),
    .ocupado       (ocupado)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one run from a low inicio, checks busy length, latency and product, then drops inicio.
  task automatic run_op(input logic [7:0] q, input logic [7:0] m, input logic [15:0] exp,
                        input int chg_at, input logic [7:0] chg_val, input string name);
    int busy;
    bit seen;
    logic [15:0] want;
    multiplicador = q;
    multiplicando = m;
    inicio = 1'b1;
    sb.push_back(exp);
    busy = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (listo) seen = 1'b1;
      else if (ocupado) busy++;
      if (i == chg_at) multiplicando = chg_val;
    end
    n_vec++;
    if (seen !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: listo got %b want 1", name, seen);
    end
    n_vec++;
    if (busy !== 8) begin
      n_err++;
      $display("FAIL %s_busy_cycles: got %0d want 8", name, busy);
    end
    n_vec++;
    if (ocupado !== 1'b0) begin
      n_err++;
      $display("FAIL %s_ocupado_done: got %b want 0", name, ocupado);
    end
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_scoreboard: got empty queue want entry", name);
    end else begin
      want = sb.pop_front();
      n_vec++;
      if (producto !== want) begin
        n_err++;
        $display("FAIL %s_producto: got %h want %h", name, producto, want);
      end
    end
    inicio = 1'b0;
    tick();
    n_vec++;
    if (listo !== 1'b0) begin
      n_err++;
      $display("FAIL %s_listo_drop: got %b want 0", name, listo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inicio = 1'b1;
    multiplicador = 8'h03;
    multiplicando = 8'h05;
    repeat (2) tick();
    inicio = 1'b0;
    tick();
    inicio = 1'b1;
    tick();
    n_vec++;
    if (ocupado !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wins_start: ocupado got %b want 0", ocupado);
    end
    reset = 1'b0;
    repeat (5) tick();
    n_vec++;
    if (producto !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_producto: got %h want 0000", producto);
    end
    n_vec++;
    if ({listo, ocupado} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_held_level: listo/ocupado got %b want 00", {listo, ocupado});
    end
    inicio = 1'b0;
    tick();
  endtask

  task automatic test_products();
    logic [7:0]  tq[8] = '{8'h03, 8'hFD, 8'h07, 8'hF9, 8'h80, 8'h80, 8'h7F, 8'h00};
    logic [7:0]  tm[8] = '{8'h05, 8'h05, 8'hFA, 8'hFA, 8'h80, 8'h7F, 8'h7F, 8'hFF};
    logic [15:0] te[8] = '{16'h000F, 16'hFFF1, 16'hFFD6, 16'h002A,
                           16'h4000, 16'hC080, 16'h3F01, 16'h0000};
    for (int i = 0; i < 8; i++)
      run_op(tq[i], tm[i], te[i], -1, 8'h00, $sformatf("prod%0d", i));
  endtask

  task automatic test_hold_rearm();
    int busy;
    bit was_listo;
    logic [15:0] want;
    multiplicador = 8'h07;
    multiplicando = 8'hFA;
    inicio = 1'b1;
    sb.push_back(16'hFFD6);
    busy = 0;
    was_listo = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (ocupado) busy++;
      if (listo && !was_listo && sb.size() != 0) begin
        want = sb.pop_front();
        n_vec++;
        if (producto !== want) begin
          n_err++;
          $display("FAIL hold_producto: got %h want %h", producto, want);
        end
      end
      was_listo = listo;
    end
    n_vec++;
    if (busy !== 8) begin
      n_err++;
      $display("FAIL hold_single_run: busy cycles got %0d want 8", busy);
    end
    n_vec++;
    if (listo !== 1'b1) begin
      n_err++;
      $display("FAIL hold_listo_high: got %b want 1", listo);
    end
    inicio = 1'b0;
    tick();
    n_vec++;
    if (listo !== 1'b0) begin
      n_err++;
      $display("FAIL hold_listo_drop: got %b want 0", listo);
    end
    n_vec++;
    if (producto !== 16'hFFD6) begin
      n_err++;
      $display("FAIL hold_producto_kept: got %h want ffd6", producto);
    end
    run_op(8'hF6, 8'h0B, 16'hFF92, -1, 8'h00, "rearm");
  endtask

  task automatic test_reset_midrun();
    multiplicador = 8'h03;
    multiplicando = 8'h05;
    inicio = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ({producto, listo, ocupado} !== 18'h0) begin
      n_err++;
      $display("FAIL midrun_reset: producto/listo/ocupado got %h/%b/%b want 0000/0/0",
               producto, listo, ocupado);
    end
    begin
      int busy = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (ocupado || listo) busy++;
      end
      n_vec++;
      if (busy !== 0) begin
        n_err++;
        $display("FAIL midrun_no_restart: active cycles got %0d want 0", busy);
      end
    end
    inicio = 1'b0;
    tick();
    run_op(8'h03, 8'h05, 16'h000F, -1, 8'h00, "after_reset");
  endtask

  task automatic test_operand_change();
    run_op(8'h03, 8'h05, 16'h000F, 2, 8'h7F, "opchange");
  endtask

  task automatic test_back_to_back();
    logic [7:0] q, m;
    logic signed [15:0] e;
    for (int i = 0; i < 6; i++) begin
      q = 8'($urandom);
      m = 8'($urandom);
      e = $signed(q) * $signed(m);
      run_op(q, m, e, -1, 8'h00, $sformatf("b2b%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_hold_rearm();
    test_reset_midrun();
    test_operand_change();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
